// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder: slice width,
// controller state encoding and the sizing rule for the nibble counter.
package nibble_add_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Counter bits needed to address WIDTH/NIB_W nibbles; at least one bit.
  function automatic int idx_width(input int width);
    int nib;
    nib = width / NIB_W;
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/nibble_add_seq_if.sv
// Operand/result handshake bundle for nibble_add_seq. The master side
// supplies operands and consumes results; the slave side is the adder.
interface nibble_add_seq_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, busy
  );

endinterface

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice. Exposes the carry
// into bit 3 as well as the carry out so the caller can derive overflow.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c3,
  output logic       c4
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is flattened to two levels so no ripple path exists.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign c3 = c[3];
  assign s  = p ^ c;

endmodule

// File: rtl/nibble_add_seq.sv
// WIDTH-bit add/subtract built from one shared 4-bit lookahead slice, one
// nibble per cycle LSB first, with the inter-nibble carry held in a register.
module nibble_add_seq
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  nibble_add_seq_if.slave   bus
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = idx_width(WIDTH);

  typedef logic [IDX_W-1:0] idx_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  idx_t             idx_q;

  logic             accept;
  logic             last_nib;
  logic [IDX_W+1:0] base;
  logic [NIB_W-1:0] slice_s;
  logic             slice_c3;
  logic             slice_c4;

  assign last_nib = (idx_q == idx_t'(NIB - 1));
  assign base     = {idx_q, 2'b00};

  cla4_slice u_slice (
    .a  (a_q[base +: NIB_W]),
    .b  (b_q[base +: NIB_W]),
    .ci (carry_q),
    .s  (slice_s),
    .c3 (slice_c3),
    .c4 (slice_c4)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_nib) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order within the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: the operand and result registers are all reset; an abort must leave
  // no residue, and these are plain flops rather than a memory array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1: invert b once and seed the carry with 1.
      a_q     <= bus.a;
      b_q     <= bus.sub ? ~bus.b : bus.b;
      carry_q <= bus.sub | bus.cin;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      sum_q[base +: NIB_W] <= slice_s;
      carry_q              <= slice_c4;
      if (last_nib) begin
        cout_q <= slice_c4;
        ovf_q  <= slice_c3 ^ slice_c4;
      end else begin
        idx_q <= idx_q + idx_t'(1);
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Randomised and directed bench for nibble_add_seq (WIDTH=16) checked against
// a whole-word arithmetic reference model.
module tb_nibble_add_seq;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  nibble_add_seq_if #(.WIDTH(W)) bus ();

  nibble_add_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole-word reference: returns {overflow, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] be;
    logic [W:0]   full;
    logic         ovf;
    be   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + (W+1)'(sub ? 1'b1 : cin);
    ovf  = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full[W], full[W-1:0]};
  endfunction

  // Presents operands at a negedge and returns at the negedge after acceptance.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    int n;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Waits for out_valid, checks latency and result, then drains the result.
  task automatic collect(input string name, input logic [W+1:0] exp, input bit drain);
    int cyc;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != NIB) begin
      errors++;
      $display("FAIL %s latency got %0d required %0d", name, cyc, NIB);
    end
    checks++;
    if ({bus.overflow, bus.cout, bus.sum} !== exp) begin
      errors++;
      $display("FAIL %s result ovf/cout/sum got %b/%b/%h required %b/%b/%h", name,
               bus.overflow, bus.cout, bus.sum, exp[W+1], exp[W], exp[W-1:0]);
    end
    if (drain) begin
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s release in_ready/out_valid got %b/%b required 1/0",
                 name, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.sum, bus.cout, bus.overflow}
        !== {3'b100, {W{1'b0}}, 2'b00}) begin
      errors++;
      $display("FAIL %s rdy/vld/busy/sum/cout/ovf got %b/%b/%b/%h/%b/%b required 1/0/0/0000/0/0",
               name, bus.in_ready, bus.out_valid, bus.busy, bus.sum, bus.cout, bus.overflow);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("after_reset");
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [8] = '{16'h1234, 16'hFFFF, 16'hFFFE, 16'h7FFF,
                             16'h8000, 16'h0005, 16'h0007, 16'h0000};
    logic [W-1:0] tb [8] = '{16'h0FFF, 16'h0001, 16'h0000, 16'h0001,
                             16'h0001, 16'h0007, 16'h0005, 16'h0000};
    logic         tc [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic         ts [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    // Hand-computed results for the vectors above: {overflow, cout, sum}.
    logic [W+1:0] te [8] = '{{2'b00, 16'h2233}, {2'b01, 16'h0000}, {2'b00, 16'hFFFF},
                             {2'b10, 16'h8000}, {2'b11, 16'h7FFF}, {2'b00, 16'hFFFE},
                             {2'b01, 16'h0002}, {2'b00, 16'h0001}};
    for (int i = 0; i < 8; i++) begin
      issue(ta[i], tb[i], tc[i], ts[i]);
      collect($sformatf("directed%0d", i), te[i], 1'b1);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         s;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom);
      s = 1'($urandom);
      if (i % 5 == 0) a = {1'b0, {(W-1){1'b1}}};
      issue(a, b, c, s);
      collect($sformatf("random%0d", i), model(a, b, c, s), 1'b1);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    issue(16'hABCD, 16'h1111, 1'b1, 1'b0);
    collect("bp_first", model(16'hABCD, 16'h1111, 1'b1, 1'b0), 1'b0);
    held = bus.sum;
    bus.in_valid = 1'b1;
    bus.a        = 16'h0F0F;
    bus.b        = 16'h0101;
    bus.cin      = 1'b0;
    bus.sub      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum !== held) begin
        errors++;
        $display("FAIL bp_hold%0d vld/rdy/sum got %b/%b/%h required 1/0/%h",
                 i, bus.out_valid, bus.in_ready, bus.sum, held);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release rdy/busy got %b/%b required 1/0", bus.in_ready, bus.busy);
    end
    issue(16'h0F0F, 16'h0101, 1'b0, 1'b1);
    collect("bp_pending", model(16'h0F0F, 16'h0101, 1'b0, 1'b1), 1'b1);
  endtask

  task automatic test_reset_mid_run();
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrun_release");
    issue(16'h0001, 16'h0002, 1'b0, 1'b0);
    collect("post_abort", {2'b00, 16'h0003}, 1'b1);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
